// File: rtl/button_pkg.sv
// Shared types and constants for the button conditioning blocks: hold-state
// encoding, hold-counter sizing and the 100 MHz board defaults.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } hold_state_e;

    localparam int DEF_N              = 4;
    localparam int DEF_DEBOUNCE_WIDTH = 20;
    localparam int DEF_REPEAT_DELAY   = 25_000_000;
    localparam int DEF_REPEAT_PERIOD  = 5_000_000;
    localparam int DEF_LONG_PRESS     = 100_000_000;

    // One spare bit above the largest compare value, so saturation can never
    // land on a value that triggers a repeat or long-press.
    function automatic int hold_cnt_width(input int delay, input int period, input int long_press);
        int m;
        m = delay;
        if (period > m) m = period;
        if (long_press > m) m = long_press;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, counting debouncer, registered
// press/release edges and the hold FSM (auto-repeat and one-shot long-press).
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_WIDTH = DEF_DEBOUNCE_WIDTH,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
    parameter int LONG_PRESS     = DEF_LONG_PRESS
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic press,
    output logic release_pulse,
    output logic event_pulse,
    output logic long_press,
    output logic held
);

    localparam int HW = hold_cnt_width(REPEAT_DELAY, REPEAT_PERIOD, LONG_PRESS);
    localparam int PW = $clog2(REPEAT_PERIOD) + 1;

    localparam logic [DEBOUNCE_WIDTH-1:0] DB_ONES  = '1;
    localparam logic [DEBOUNCE_WIDTH-1:0] DB_LAST  = DB_ONES - DEBOUNCE_WIDTH'(1);
    localparam logic [HW-1:0]             HOLD_MAX = '1;
    localparam logic [HW-1:0]             RD_CNT   = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0]             LP_CNT   = HW'(LONG_PRESS);
    localparam logic [PW-1:0]             RP_CNT   = PW'(REPEAT_PERIOD);

    logic                      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DEBOUNCE_WIDTH-1:0] db_cnt_q, db_cnt_d;
    logic                      held_q, held_d, held_prev_q, held_prev_d;
    logic                      press_q, press_d, release_q, release_d;
    logic                      event_q, event_d, long_q, long_d;
    hold_state_e               state_q, state_d;
    logic [HW-1:0]             hold_cnt_q, hold_cnt_d;
    logic [PW-1:0]             per_cnt_q, per_cnt_d;
    logic                      lp_done_q, lp_done_d;
    logic                      rise, fall, rep, lp;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        sync1_d     = btn_in;
        sync2_d     = sync1_q;
        db_cnt_d    = '0;
        held_d      = held_q;
        held_prev_d = held_q;
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        per_cnt_d   = per_cnt_q;
        lp_done_d   = lp_done_q;
        rep         = 1'b0;
        lp          = 1'b0;

        // Flip on the edge where the counter would reach all-ones, so the
        // counter itself never holds that value and restarts from zero.
        if (sync2_q != held_q) begin
            if (db_cnt_q == DB_LAST) held_d = ~held_q;
            else                     db_cnt_d = db_cnt_q + DEBOUNCE_WIDTH'(1);
        end

        rise = held_q & ~held_prev_q;
        fall = ~held_q & held_prev_q;

        if (fall) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            per_cnt_d  = '0;
            lp_done_d  = 1'b0;
        end else if (rise) begin
            state_d    = DELAY;
            hold_cnt_d = HW'(1);
            per_cnt_d  = '0;
            lp_done_d  = 1'b0;
        end else if (state_q != IDLE) begin
            if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HW'(1);
            if (hold_cnt_q == LP_CNT && !lp_done_q) begin
                lp        = 1'b1;
                lp_done_d = 1'b1;
            end
            case (state_q)
                DELAY: begin
                    // Late enable (count already past the delay) enters REPEAT silently.
                    if (repeat_en && hold_cnt_q >= RD_CNT) begin
                        state_d   = REPEAT;
                        per_cnt_d = PW'(1);
                        rep       = (hold_cnt_q == RD_CNT);
                    end
                end
                REPEAT: begin
                    if (!repeat_en) begin
                        state_d   = DELAY;
                        per_cnt_d = '0;
                    end else if (per_cnt_q == RP_CNT) begin
                        rep       = 1'b1;
                        per_cnt_d = PW'(1);
                    end else begin
                        per_cnt_d = per_cnt_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end

        press_d   = rise;
        release_d = fall;
        event_d   = rise | rep;
        long_d    = lp;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_cnt_q    <= '0;
            held_q      <= 1'b0;
            held_prev_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            event_q     <= 1'b0;
            long_q      <= 1'b0;
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            per_cnt_q   <= '0;
            lp_done_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_cnt_q    <= db_cnt_d;
            held_q      <= held_d;
            held_prev_q <= held_prev_d;
            press_q     <= press_d;
            release_q   <= release_d;
            event_q     <= event_d;
            long_q      <= long_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            per_cnt_q   <= per_cnt_d;
            lp_done_q   <= lp_done_d;
        end
    end

    assign press         = press_q;
    assign release_pulse = release_q;
    assign event_pulse   = event_q;
    assign long_press    = long_q;
    assign held          = held_q;

endmodule

// File: rtl/button_array_unit.sv
// N independent button channels turning bouncy board buttons into clean
// single-cycle press/release/repeat/long-press events.
module button_array_unit
    import button_pkg::*;
#(
    parameter int N              = DEF_N,
    parameter int DEBOUNCE_WIDTH = DEF_DEBOUNCE_WIDTH,
    parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEF_REPEAT_PERIOD,
    parameter int LONG_PRESS     = DEF_LONG_PRESS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] event_pulse,
    output logic [N-1:0] long_press,
    output logic [N-1:0] held
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .LONG_PRESS    (LONG_PRESS)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .btn_in       (in[i]),
            .repeat_en    (repeat_en[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i]),
            .event_pulse  (event_pulse[i]),
            .long_press   (long_press[i]),
            .held         (held[i])
        );
    end

endmodule

// File: tb/tb_button_array_unit.sv
// Scoreboard bench for button_array_unit: a cycle-stamped reference model
// queues expected outputs; a negedge monitor pops and compares them.
module tb_button_array_unit;

    localparam int N      = 4;
    localparam int W      = 3;
    localparam int RD     = 20;
    localparam int RP     = 5;
    localparam int LP     = 40;
    localparam int STABLE = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] in = '1;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] press, release_pulse, event_pulse, long_press, held;

    button_array_unit #(
        .N(N), .DEBOUNCE_WIDTH(W), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .LONG_PRESS(LP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .repeat_en    (repeat_en),
        .press        (press),
        .release_pulse(release_pulse),
        .event_pulse  (event_pulse),
        .long_press   (long_press),
        .held         (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [N-1:0] press, rel, ev, lp, held;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: raw samples are kept as a history; the debounced level
    // flips once the synchronized view (two samples late) has disagreed with it
    // for STABLE consecutive edges. Hold timing is tracked as cycle stamps.
    logic [STABLE:0] hist[N];
    logic            m_held[N], m_held_prev[N], m_active[N], m_rep[N], m_lp_done[N];
    int              m_p[N], m_next[N];
    exp_t            m_e;
    logic [N-1:0]    m_held_before;
    logic            pr, rl, rp, lpp;
    int              age;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            for (int ch = 0; ch < N; ch++) begin
                hist[ch] = '0; m_held[ch] = 1'b0; m_held_prev[ch] = 1'b0;
                m_active[ch] = 1'b0; m_rep[ch] = 1'b0; m_lp_done[ch] = 1'b0;
                m_p[ch] = 0; m_next[ch] = 0;
            end
        end else begin
            m_e.cyc = cyc;
            for (int ch = 0; ch < N; ch++) begin
                m_held_before[ch] = m_held[ch];
                pr = m_held[ch] & ~m_held_prev[ch];
                rl = ~m_held[ch] & m_held_prev[ch];
                m_held_prev[ch] = m_held[ch];
                if (hist[ch][STABLE:1] == {STABLE{~m_held[ch]}}) m_held[ch] = ~m_held[ch];
                hist[ch] = {hist[ch][STABLE-1:0], in[ch]};
                rp = 1'b0;
                lpp = 1'b0;
                if (rl) begin
                    m_active[ch] = 1'b0;
                end else if (pr) begin
                    m_active[ch] = 1'b1; m_p[ch] = cyc; m_rep[ch] = 1'b0; m_lp_done[ch] = 1'b0;
                end else if (m_active[ch]) begin
                    age = cyc - m_p[ch];
                    if (age == LP && !m_lp_done[ch]) begin lpp = 1'b1; m_lp_done[ch] = 1'b1; end
                    if (!m_rep[ch]) begin
                        if (repeat_en[ch] && age >= RD) begin
                            m_rep[ch] = 1'b1; m_next[ch] = cyc + RP; rp = (age == RD);
                        end
                    end else if (!repeat_en[ch]) begin
                        m_rep[ch] = 1'b0;
                    end else if (cyc == m_next[ch]) begin
                        rp = 1'b1; m_next[ch] = cyc + RP;
                    end
                end
                m_e.press[ch] = pr;
                m_e.rel[ch]   = rl;
                m_e.ev[ch]    = pr | rp;
                m_e.lp[ch]    = lpp;
                m_e.held[ch]  = m_held[ch];
            end
            if ((m_e.press | m_e.rel | m_e.ev | m_e.lp) != '0 || m_e.held != m_held_before)
                exp_q.push_back(m_e);
        end
    end

    // Monitor: acts whenever the DUT shows a pulse or a held change, or an
    // expectation is due this cycle.
    logic [N-1:0] dut_held_prev = '0;
    exp_t         mon_e;
    logic         dut_act;

    always @(negedge clk) begin
        if (!reset) begin
            dut_held_prev = '0;
        end else begin
            dut_act = (press | release_pulse | event_pulse | long_press) != '0 || held != dut_held_prev;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                check("press",      32'(press),         32'(mon_e.press));
                check("release",    32'(release_pulse), 32'(mon_e.rel));
                check("event",      32'(event_pulse),   32'(mon_e.ev));
                check("long_press", 32'(long_press),    32'(mon_e.lp));
                check("held",       32'(held),          32'(mon_e.held));
            end else if (dut_act) begin
                check("spurious_output",
                      32'({press, release_pulse, event_pulse, long_press, held ^ dut_held_prev}), 32'd0);
            end
            dut_held_prev = held;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int           dur[N], bnc[N];
    logic [N-1:0] tgt;

    initial begin
        // Reset held with all buttons down: outputs must stay zero.
        tick(1);
        check("reset_outputs_zero", 32'({press, release_pulse, event_pulse, long_press, held}), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(30);
        in = '0;
        tick(20);

        // Bouncing channel 0, then stable press.
        for (int k = 0; k < 10; k++) begin
            in[0] = ~in[0];
            tick(3);
        end
        in[0] = 1'b1;
        tick(30);
        in[0] = 1'b0;
        tick(20);

        // Long hold on channel 1 with and without auto-repeat, then late enable.
        repeat_en[1] = 1'b1; in[1] = 1'b1; tick(60); in[1] = 1'b0; tick(20);
        repeat_en[1] = 1'b0; in[1] = 1'b1; tick(60); in[1] = 1'b0; tick(20);
        in[1] = 1'b1; tick(45); repeat_en[1] = 1'b1; tick(20); repeat_en[1] = 1'b0;
        tick(5); in[1] = 1'b0; tick(20);

        // Channels 2 and 3 pressed together, channel 3 released early.
        repeat_en[3:2] = 2'b11; in[3:2] = 2'b11;
        tick(22); in[3] = 1'b0;
        tick(40); in[2] = 1'b0;
        tick(20); repeat_en = '0;

        // Reset while channel 0 auto-repeats: outputs drop immediately.
        repeat_en[0] = 1'b1; in[0] = 1'b1;
        tick(40);
        check("held_before_reset", 32'(held[0]), 32'd1);
        reset = 1'b0;
        #1;
        check("async_reset_outputs_zero", 32'({press, release_pulse, event_pulse, long_press, held}), 32'd0);
        tick(3);
        check("reset_mid_hold_zero", 32'({press, release_pulse, event_pulse, long_press, held}), 32'd0);
        reset = 1'b1;
        tick(60);
        in[0] = 1'b0;
        tick(20);

        // Randomized bouncy presses and repeat enable changes on all channels.
        tgt = '0;
        for (int ch = 0; ch < N; ch++) begin
            dur[ch] = $urandom_range(1, 40);
            bnc[ch] = 0;
        end
        for (int t = 0; t < 4000; t++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (dur[ch] == 0) begin
                    tgt[ch] = ~tgt[ch];
                    dur[ch] = $urandom_range(4, 120);
                    bnc[ch] = $urandom_range(0, 8);
                end
                dur[ch]--;
                if (bnc[ch] > 0) begin
                    bnc[ch]--;
                    in[ch] = 1'($urandom_range(0, 1));
                end else begin
                    in[ch] = tgt[ch];
                end
                if ($urandom_range(0, 59) == 0) repeat_en[ch] = ~repeat_en[ch];
            end
            tick(1);
        end
        in = '0;
        tick(30);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
